// File: rtl/uart_frame_parser.sv
// uart_frame_parser: pops bytes from the UART RX FIFO, finds SOF/LEN/payload/CHK
// frames, buffers the payload and only streams it out once the checksum matches.
//
// state   | meaning
// --------+------------------------------------------------------------
// HUNT    | discarding bytes until an SOF byte is seen
// LEN     | waiting for the length byte
// PAYLOAD | storing payload bytes into the buffer, accumulating the sum
// CHK     | waiting for the checksum byte
// DRAIN   | streaming the validated payload; RX reads are paused
module uart_frame_parser #(
    parameter int              DBIT    = 8,
    parameter int              MAX_LEN = 16,
    parameter logic [DBIT-1:0] SOF     = DBIT'(8'hA5),
    parameter int              TIMEOUT = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    output logic            m_valid,
    output logic [DBIT-1:0] m_data,
    output logic            m_last,
    input  logic            m_ready,
    output logic            frame_ok,
    output logic            frame_err,
    output logic [1:0]      err_code
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t          state, state_nxt;
    logic            rd_pend;
    logic            byte_vld;
    logic [DBIT-1:0] byte_reg;
    logic [DBIT-1:0] buf_mem [MAX_LEN];
    logic [IW-1:0]   len;
    logic [IW-1:0]   idx;
    logic [DBIT-1:0] sum;
    logic [TW-1:0]   tmo_cnt;

    logic            ok_nxt;
    logic            err_nxt;
    logic [1:0]      code_nxt;
    logic            len_bad;
    logic            at_last;
    logic            tmo_hit;
    logic            in_frame;
    logic            hs;

    // One outstanding pop at a time; reads stop while the payload is draining.
    assign rd_uart  = !rx_empty && !rd_pend && !byte_vld && (state != S_DRAIN) && rst_n;

    assign len_bad  = (byte_reg == '0) || (byte_reg > DBIT'(MAX_LEN));
    assign at_last  = (idx == len - IW'(1));
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT));
    assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    assign hs       = m_valid && m_ready;

    // Output data is gated by m_valid so it reads 0 whenever nothing is offered.
    assign m_data   = m_valid ? buf_mem[idx[AW-1:0]] : '0;
    assign m_last   = m_valid && at_last;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HUNT;
        else        state <= state_nxt;
    end

    // Next-state decode and frame verdicts.
    always_comb begin
        state_nxt = state;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = err_code;
        case (state)
            S_HUNT: begin
                if (byte_vld && byte_reg == SOF) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (byte_vld) begin
                    if (len_bad) begin
                        err_nxt   = 1'b1;
                        code_nxt  = 2'd1;
                        state_nxt = S_HUNT;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    err_nxt   = 1'b1;
                    code_nxt  = 2'd3;
                    state_nxt = S_HUNT;
                end
            end
            S_PAYLOAD: begin
                if (byte_vld) begin
                    if (at_last) state_nxt = S_CHK;
                end else if (tmo_hit) begin
                    err_nxt   = 1'b1;
                    code_nxt  = 2'd3;
                    state_nxt = S_HUNT;
                end
            end
            S_CHK: begin
                if (byte_vld) begin
                    if (byte_reg == sum) begin
                        ok_nxt    = 1'b1;
                        state_nxt = S_DRAIN;
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = 2'd2;
                        state_nxt = S_HUNT;
                    end
                end else if (tmo_hit) begin
                    err_nxt   = 1'b1;
                    code_nxt  = 2'd3;
                    state_nxt = S_HUNT;
                end
            end
            S_DRAIN: begin
                if (hs && at_last) state_nxt = S_HUNT;
            end
            default: state_nxt = S_HUNT;
        endcase
    end

    // Fetch pipeline, frame bookkeeping, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend   <= 1'b0;
            byte_vld  <= 1'b0;
            byte_reg  <= '0;
            len       <= '0;
            idx       <= '0;
            sum       <= '0;
            tmo_cnt   <= '0;
            m_valid   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            rd_pend <= rd_uart;
            if (rd_pend) begin
                byte_reg <= r_data;
                byte_vld <= 1'b1;
            end else if (byte_vld) begin
                byte_vld <= 1'b0;
            end

            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;

            if (!in_frame || byte_vld || state_nxt != state) tmo_cnt <= '0;
            else                                             tmo_cnt <= tmo_cnt + TW'(1);

            m_valid <= (state == S_DRAIN) && !(hs && at_last);

            case (state)
                S_LEN: begin
                    if (byte_vld && !len_bad) begin
                        len <= IW'(byte_reg);
                        sum <= byte_reg;
                        idx <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (byte_vld) begin
                        sum <= sum + byte_reg;
                        idx <= idx + IW'(1);
                    end
                end
                S_CHK: begin
                    if (byte_vld && byte_reg == sum) idx <= '0;
                end
                S_DRAIN: begin
                    if (hs) idx <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Payload buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && byte_vld) buf_mem[idx[AW-1:0]] <= byte_reg;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with an RX FIFO model upstream and a
// payload scoreboard downstream.
module tb_uart_frame_parser;

    localparam int TMO = 200;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_empty;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready = 1'b1;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    int vectors = 0;
    int miscompares = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int mv_cycles = 0;
    int pat_en = 0;
    int pat_k = 0;

    logic [7:0] rx_mem [1024];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] fb[$];
    exp_t       exp_q[$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    uart_frame_parser #(
        .DBIT(8), .MAX_LEN(16), .SOF(8'hA5), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_ready(m_ready), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Upstream RX FIFO: data appears the cycle after the pop request.
    assign rx_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (rd_uart) begin
            r_data <= rx_mem[rd_ptr[9:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Stream monitor: scoreboard pops, stall stability, no reads while draining.
    always @(negedge clk) begin
        exp_t e;
        if (frame_ok)  ok_cnt++;
        if (frame_err) err_cnt++;
        if (m_valid) begin
            mv_cycles++;
            vectors++;
            assert (rd_uart === 1'b0) else begin
                miscompares++;
                $error("FAIL no_rd_in_drain: observed rd_uart=%b expected 0", rd_uart);
            end
            if (prev_stall) begin
                vectors++;
                assert ({m_data, m_last} === {prev_data, prev_last}) else begin
                    miscompares++;
                    $error("FAIL stall_hold: observed %h/%b expected %h/%b", m_data, m_last, prev_data, prev_last);
                end
            end
            if (m_ready) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL stream_unexpected: observed byte %h expected no output", m_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    vectors++;
                    assert (m_data === e.d && m_last === e.l) else begin
                        miscompares++;
                        $error("FAIL stream_byte: observed %h last=%b expected %h last=%b", m_data, m_last, e.d, e.l);
                    end
                end
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pat_en != 0) begin
            m_ready = ((pat_k % 4) == 0) || ((pat_k % 4) == 3);
            pat_k++;
        end
    endtask

    task automatic send_fb();
        foreach (fb[i]) begin
            rx_mem[wr_ptr[9:0]] = fb[i];
            wr_ptr++;
        end
    endtask

    task automatic expect_from(input int s);
        int n;
        n = int'(fb[s+1]);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.d = fb[s+2+i];
            e.l = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic settle(input string tag);
        int quiet;
        int cyc;
        quiet = 0;
        cyc = 0;
        while ((quiet < 8 || exp_q.size() != 0) && cyc < 3000) begin
            tick();
            cyc++;
            if (rx_empty && !m_valid && !rd_uart) quiet++;
            else                                   quiet = 0;
        end
        check({tag, "_settle"}, 32'(cyc < 3000), 32'd1);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int         ok0;
        int         err0;
        int         mv0;
        int         waited;
        logic [7:0] s;
        logic [7:0] b;

        // reset: a byte is waiting but no pop may happen while in reset
        fb = '{8'h00};
        send_fb();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_uart",   32'(rd_uart),   32'd0);
        check("rst_m_valid",   32'(m_valid),   32'd0);
        check("rst_m_data",    32'(m_data),    32'd0);
        check("rst_m_last",    32'(m_last),    32'd0);
        check("rst_frame_ok",  32'(frame_ok),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_code",  32'(err_code),  32'd0);
        rst_n = 1'b1;

        // good frame
        ok0 = ok_cnt; err0 = err_cnt;
        fb = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_fb(); expect_from(0); settle("good");
        check("good_ok",   32'(ok_cnt - ok0),   32'd1);
        check("good_err",  32'(err_cnt - err0), 32'd0);
        check("good_code", 32'(err_code),       32'd0);

        // bad checksum
        ok0 = ok_cnt; err0 = err_cnt; mv0 = mv_cycles;
        fb = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        send_fb(); settle("badchk");
        check("badchk_err",   32'(err_cnt - err0),   32'd1);
        check("badchk_code",  32'(err_code),         32'd2);
        check("badchk_ok",    32'(ok_cnt - ok0),     32'd0);
        check("badchk_nostr", 32'(mv_cycles - mv0),  32'd0);

        // good frame after the bad one; frame_ok leaves err_code alone
        ok0 = ok_cnt;
        fb = '{8'hA5, 8'h01, 8'h07, 8'h08};
        send_fb(); expect_from(0); settle("good2");
        check("good2_ok",   32'(ok_cnt - ok0), 32'd1);
        check("good2_code", 32'(err_code),     32'd2);

        // LEN = 0
        err0 = err_cnt;
        fb = '{8'hA5, 8'h00};
        send_fb(); settle("len0");
        check("len0_err",  32'(err_cnt - err0), 32'd1);
        check("len0_code", 32'(err_code),       32'd1);

        // LEN = MAX_LEN + 1
        err0 = err_cnt;
        fb = '{8'hA5, 8'h11};
        send_fb(); settle("len17");
        check("len17_err",  32'(err_cnt - err0), 32'd1);
        check("len17_code", 32'(err_code),       32'd1);

        // LEN = MAX_LEN, checksum wraps
        ok0 = ok_cnt; err0 = err_cnt;
        fb = '{8'hA5, 8'h10};
        s = 8'h10;
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 29 + 5);
            fb.push_back(b);
            s = s + b;
        end
        fb.push_back(s);
        send_fb(); expect_from(0); settle("len16");
        check("len16_ok",  32'(ok_cnt - ok0),   32'd1);
        check("len16_err", 32'(err_cnt - err0), 32'd0);

        // leading junk and SOF-valued payload
        ok0 = ok_cnt; err0 = err_cnt;
        fb = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C};
        send_fb(); expect_from(2); settle("resync");
        check("resync_ok",  32'(ok_cnt - ok0),   32'd1);
        check("resync_err", 32'(err_cnt - err0), 32'd0);

        // backpressure, with more bytes waiting in the FIFO during DRAIN
        ok0 = ok_cnt;
        pat_en = 1; pat_k = 0;
        fb = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E, 8'h00, 8'h00, 8'h00};
        send_fb(); expect_from(0); settle("bp");
        pat_en = 0; m_ready = 1'b1;
        check("bp_ok", 32'(ok_cnt - ok0), 32'd1);

        // inter-byte timeout inside a frame
        err0 = err_cnt;
        fb = '{8'hA5, 8'h02, 8'h11};
        send_fb();
        waited = 0;
        while (err_cnt == err0 && waited < TMO + 200) begin
            tick();
            waited++;
        end
        check("tmo_err",       32'(err_cnt - err0), 32'd1);
        check("tmo_code",      32'(err_code),       32'd3);
        check("tmo_not_early", 32'(waited >= TMO),  32'd1);
        settle("tmo");

        // reset in the middle of DRAIN
        m_ready = 1'b0;
        fb = '{8'hA5, 8'h02, 8'h33, 8'h44, 8'h79};
        send_fb(); expect_from(0);
        waited = 0;
        while (!m_valid && waited < 100) begin
            tick();
            waited++;
        end
        check("drain_reached", 32'(m_valid), 32'd1);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid",  32'(m_valid),  32'd0);
        check("mid_rst_m_data",   32'(m_data),   32'd0);
        check("mid_rst_m_last",   32'(m_last),   32'd0);
        check("mid_rst_err_code", 32'(err_code), 32'd0);
        exp_q.delete();
        tick(); tick(); tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        ok0 = ok_cnt; err0 = err_cnt;
        send_fb(); expect_from(0); settle("restart");
        check("restart_ok",  32'(ok_cnt - ok0),   32'd1);
        check("restart_err", 32'(err_cnt - err0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
